// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that detect RAW and
// counter-full hazards at issue, with writeback retirement and pipeline flush.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_wr,
    input  logic [3:0]  issue_dst,
    input  logic        src1_used,
    input  logic        src2_used,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dst,
    input  logic        flush,
    output logic        stall,
    output logic        issue_ack,
    output logic [15:0] busy,
    output logic [5:0]  total_pend,
    output logic        wb_err
);

    localparam logic [CNT_W-1:0] MAXP = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg  [16];
    logic [CNT_W-1:0] cnt_next [16];
    logic             wb_err_reg;

    logic raw_hazard;
    logic full_hazard;
    logic issue_inc;
    logic wb_to_empty;

    // Hazards look only at registered counters, so a same-cycle writeback
    // never releases a stall early.
    assign raw_hazard  = (src1_used && (cnt_reg[src1] != '0)) ||
                         (src2_used && (cnt_reg[src2] != '0));
    assign full_hazard = issue_wr && (cnt_reg[issue_dst] == MAXP);
    assign stall       = issue_valid && (raw_hazard || full_hazard);
    assign issue_ack   = issue_valid && !stall;
    assign issue_inc   = issue_ack && issue_wr;

    // A writeback paired with an accepted issue to the same register cancels
    // out, so it is not an error even when the counter is zero.
    assign wb_to_empty = wb_valid && (cnt_reg[wb_dst] == '0) &&
                         !(issue_inc && (issue_dst == wb_dst));

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_reg
            logic inc_hit;
            logic wb_hit;

            assign inc_hit = issue_inc && (issue_dst == 4'(gi));
            assign wb_hit  = wb_valid && (wb_dst == 4'(gi));

            assign cnt_next[gi] = (inc_hit && wb_hit)              ? cnt_reg[gi] :
                                  inc_hit                          ? cnt_reg[gi] + ONE :
                                  (wb_hit && (cnt_reg[gi] != '0))  ? cnt_reg[gi] - ONE :
                                                                     cnt_reg[gi];
            assign busy[gi] = (cnt_reg[gi] != '0);
        end
    endgenerate

    always_comb begin
        total_pend = '0;
        for (int i = 0; i < 16; i++) begin
            total_pend = total_pend + 6'(cnt_reg[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '{default: '0};
            wb_err_reg <= 1'b0;
        end else if (flush) begin
            cnt_reg    <= '{default: '0};
        end else begin
            cnt_reg    <= cnt_next;
            if (wb_to_empty) begin
                wb_err_reg <= 1'b1;
            end
        end
    end

    assign wb_err = wb_err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: hazards, counter limits,
// same-cycle issue/writeback, sticky error, flush and reset behaviour.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_wr;
    logic [3:0]  issue_dst;
    logic        src1_used;
    logic        src2_used;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic        flush;
    logic        stall;
    logic        issue_ack;
    logic [15:0] busy;
    logic [5:0]  total_pend;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_dst   (issue_dst),
        .src1_used   (src1_used),
        .src2_used   (src2_used),
        .src1        (src1),
        .src2        (src2),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .flush       (flush),
        .stall       (stall),
        .issue_ack   (issue_ack),
        .busy        (busy),
        .total_pend  (total_pend),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; issue_valid = 0; issue_wr = 0; issue_dst = 0;
        src1_used = 0; src2_used = 0; src1 = 0; src2 = 0;
        wb_valid = 0; wb_dst = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic issue_write(input logic [3:0] dst);
        issue_valid = 1; issue_wr = 1; issue_dst = dst;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
        n_checks++;
        if (busy !== 16'h0000) begin n_fail++; $display("FAIL reset_busy got %h exp 0000", busy); end
        n_checks++;
        if (total_pend !== 6'd0) begin n_fail++; $display("FAIL reset_total got %0d exp 0", total_pend); end
        n_checks++;
        if (wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wb_err got %b exp 0", wb_err); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
        $display("test_reset done");
    endtask

    task automatic test_raw();
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_dst = 4'd5;
        #1;
        n_checks++;
        if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL raw_first_ack got %b exp 1", issue_ack); end
        step();
        idle();
        issue_valid = 1; src1_used = 1; src1 = 4'd5;
        wb_valid = 1; wb_dst = 4'd5;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall got %b exp 1", stall); end
        n_checks++;
        if (issue_ack !== 1'b0) begin n_fail++; $display("FAIL raw_ack got %b exp 0", issue_ack); end
        n_checks++;
        if (busy !== 16'h0020) begin n_fail++; $display("FAIL raw_busy got %h exp 0020", busy); end
        step();
        wb_valid = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_release_stall got %b exp 0", stall); end
        n_checks++;
        if (busy !== 16'h0000) begin n_fail++; $display("FAIL raw_release_busy got %h exp 0000", busy); end
        step();
        idle();
        $display("test_raw done");
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 3; k++) issue_write(4'd3);
        issue_valid = 1; issue_wr = 1; issue_dst = 4'd3;
        wb_valid = 1; wb_dst = 4'd3;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %b exp 1", stall); end
        n_checks++;
        if (total_pend !== 6'd3) begin n_fail++; $display("FAIL full_total got %0d exp 3", total_pend); end
        n_checks++;
        if (busy !== 16'h0008) begin n_fail++; $display("FAIL full_busy got %h exp 0008", busy); end
        step();
        wb_valid = 0;
        #1;
        n_checks++;
        if (total_pend !== 6'd2) begin n_fail++; $display("FAIL full_after_wb_total got %0d exp 2", total_pend); end
        n_checks++;
        if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL full_fourth_ack got %b exp 1", issue_ack); end
        step();
        idle();
        #1;
        n_checks++;
        if (total_pend !== 6'd3) begin n_fail++; $display("FAIL full_refill_total got %0d exp 3", total_pend); end
        $display("test_full done");
    endtask

    task automatic test_same_reg();
        do_reset();
        issue_write(4'd7);
        issue_valid = 1; issue_wr = 1; issue_dst = 4'd7;
        wb_valid = 1; wb_dst = 4'd7;
        #1;
        n_checks++;
        if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL same_ack got %b exp 1", issue_ack); end
        step();
        idle();
        #1;
        n_checks++;
        if (busy !== 16'h0080) begin n_fail++; $display("FAIL same_busy got %h exp 0080", busy); end
        n_checks++;
        if (total_pend !== 6'd1) begin n_fail++; $display("FAIL same_total got %0d exp 1", total_pend); end
        n_checks++;
        if (wb_err !== 1'b0) begin n_fail++; $display("FAIL same_wb_err got %b exp 0", wb_err); end
        // Same register at counter zero: no change and no error.
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_dst = 4'd8;
        wb_valid = 1; wb_dst = 4'd8;
        step();
        idle();
        #1;
        n_checks++;
        if (busy !== 16'h0000) begin n_fail++; $display("FAIL same_zero_busy got %h exp 0000", busy); end
        n_checks++;
        if (wb_err !== 1'b0) begin n_fail++; $display("FAIL same_zero_wb_err got %b exp 0", wb_err); end
        $display("test_same_reg done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_write(4'd15);
        issue_valid = 1; issue_wr = 1; issue_dst = 4'd10;
        wb_valid = 1; wb_dst = 4'd15;
        step();
        idle();
        #1;
        n_checks++;
        if (busy !== 16'h0400) begin n_fail++; $display("FAIL b2b_busy got %h exp 0400", busy); end
        n_checks++;
        if (total_pend !== 6'd1) begin n_fail++; $display("FAIL b2b_total got %0d exp 1", total_pend); end
        $display("test_back_to_back done");
    endtask

    task automatic test_wb_err();
        do_reset();
        issue_write(4'd2);
        wb_valid = 1; wb_dst = 4'd9;
        step();
        idle();
        #1;
        n_checks++;
        if (wb_err !== 1'b1) begin n_fail++; $display("FAIL wberr_set got %b exp 1", wb_err); end
        n_checks++;
        if (busy !== 16'h0004) begin n_fail++; $display("FAIL wberr_busy got %h exp 0004", busy); end
        step();
        step();
        n_checks++;
        if (wb_err !== 1'b1) begin n_fail++; $display("FAIL wberr_sticky got %b exp 1", wb_err); end
        flush = 1;
        step();
        idle();
        #1;
        n_checks++;
        if (wb_err !== 1'b1) begin n_fail++; $display("FAIL wberr_flush got %b exp 1", wb_err); end
        rst = 1;
        step();
        rst = 0;
        #1;
        n_checks++;
        if (wb_err !== 1'b0) begin n_fail++; $display("FAIL wberr_rst got %b exp 0", wb_err); end
        $display("test_wb_err done");
    endtask

    task automatic test_flush();
        do_reset();
        issue_write(4'd1);
        issue_write(4'd1);
        issue_write(4'd4);
        #1;
        n_checks++;
        if (busy !== 16'h0012) begin n_fail++; $display("FAIL flush_pre_busy got %h exp 0012", busy); end
        n_checks++;
        if (total_pend !== 6'd3) begin n_fail++; $display("FAIL flush_pre_total got %0d exp 3", total_pend); end
        flush = 1; issue_valid = 1; issue_wr = 1; issue_dst = 4'd2;
        #1;
        n_checks++;
        if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL flush_ack got %b exp 1", issue_ack); end
        step();
        idle();
        #1;
        n_checks++;
        if (busy !== 16'h0000) begin n_fail++; $display("FAIL flush_busy got %h exp 0000", busy); end
        n_checks++;
        if (total_pend !== 6'd0) begin n_fail++; $display("FAIL flush_total got %0d exp 0", total_pend); end
        $display("test_flush done");
    endtask

    task automatic test_src_select();
        do_reset();
        issue_write(4'd15);
        issue_valid = 1; src1_used = 1; src1 = 4'd0; src2_used = 1; src2 = 4'd15;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL src2_stall got %b exp 1", stall); end
        src1_used = 0; src2_used = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL src_unused_stall got %b exp 0", stall); end
        src1_used = 1; src1 = 4'd15;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL src1_stall got %b exp 1", stall); end
        issue_valid = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL novalid_stall got %b exp 0", stall); end
        idle();
        $display("test_src_select done");
    endtask

    task automatic test_rst_mid();
        do_reset();
        issue_write(4'd6);
        issue_write(4'd11);
        rst = 1; wb_valid = 1; wb_dst = 4'd0; issue_valid = 1; issue_wr = 1; issue_dst = 4'd12;
        step();
        idle();
        #1;
        n_checks++;
        if (busy !== 16'h0000) begin n_fail++; $display("FAIL rstmid_busy got %h exp 0000", busy); end
        n_checks++;
        if (wb_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_wb_err got %b exp 0", wb_err); end
        $display("test_rst_mid done");
    endtask

    initial begin
        test_reset();
        test_raw();
        test_full();
        test_same_reg();
        test_back_to_back();
        test_wb_err();
        test_flush();
        test_src_select();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
